// File: rtl/add_sub_arbiter_seq.sv
// Shared 16-bit add/subtract engine, two-requester round-robin arbitration,
// computed nibble-serially through one 4-bit slice with a registered carry.
module add_sub_arbiter_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        sub0,
    input  logic        sub1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] result,
    output logic        carry,
    output logic        overflow,
    output logic        busy
);

    // state  | meaning
    // S_IDLE | waiting for a request; arbitration happens here
    // S_CALC | one nibble per cycle, nib_idx 0..3
    // S_DONE | result visible, done pulse to owner
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      state, state_nx;
    logic [1:0]  nib_idx;
    logic [15:0] op_a, op_b;
    logic [11:0] res_sr;
    logic        op_sub, c_reg, owner, ptr;
    logic        accept, grant_sel, last_nib;
    logic [4:0]  slice_sum;

    always_comb begin
        state_nx  = state;
        accept    = (state == S_IDLE) && (req0 || req1);
        grant_sel = (req0 && req1) ? ptr : req1;
        last_nib  = (nib_idx == 2'd3);
        // Operand registers shift right, so the active nibble is always [3:0]
        slice_sum = {1'b0, op_a[3:0]} + {1'b0, op_b[3:0] ^ {4{op_sub}}} + {4'b0, c_reg};
        case (state)
            S_IDLE:  if (accept) state_nx = S_CALC;
            S_CALC:  if (last_nib) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != S_IDLE);
        gnt0  = busy && !owner;
        gnt1  = busy && owner;
        done0 = (state == S_DONE) && !owner;
        done1 = (state == S_DONE) && owner;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            nib_idx  <= 2'd0;
            op_a     <= 16'h0000;
            op_b     <= 16'h0000;
            op_sub   <= 1'b0;
            c_reg    <= 1'b0;
            res_sr   <= 12'h000;
            owner    <= 1'b0;
            ptr      <= 1'b0;
            result   <= 16'h0000;
            carry    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                owner   <= grant_sel;
                ptr     <= ~grant_sel;
                op_a    <= grant_sel ? a1 : a0;
                op_b    <= grant_sel ? b1 : b0;
                op_sub  <= grant_sel ? sub1 : sub0;
                c_reg   <= grant_sel ? sub1 : sub0;
                nib_idx <= 2'd0;
            end else if (state == S_CALC) begin
                c_reg   <= slice_sum[4];
                res_sr  <= {slice_sum[3:0], res_sr[11:4]};
                op_a    <= {4'h0, op_a[15:4]};
                op_b    <= {4'h0, op_b[15:4]};
                nib_idx <= nib_idx + 2'd1;
                // On the top nibble op_a[3]/op_b[3] are the original sign bits
                if (last_nib) begin
                    result   <= {slice_sum[3:0], res_sr};
                    carry    <= slice_sum[4];
                    overflow <= (op_a[3] == (op_b[3] ^ op_sub)) && (slice_sum[3] != op_a[3]);
                end
            end
        end
    end

endmodule

// File: tb/tb_add_sub_arbiter_seq.sv
// Directed bench for add_sub_arbiter_seq: arithmetic, arbitration, isolation, reset abort.
module tb_add_sub_arbiter_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1, sub0, sub1;
    logic [15:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] result;
    logic        carry, overflow, busy;

    int checks = 0;
    int errors = 0;

    add_sub_arbiter_seq dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .sub0(sub0), .sub1(sub1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .carry(carry), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Issues one operation from an idle engine and returns latency and outputs.
    task automatic run_op(input int who, input logic s, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output logic gnt_ok,
                          output logic [15:0] r, output logic c, output logic v);
        logic d;
        if (who == 0) begin req0 = 1'b1; sub0 = s; a0 = a; b0 = b; end
        else          begin req1 = 1'b1; sub1 = s; a1 = a; b1 = b; end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        gnt_ok = (who == 0) ? (gnt0 && !gnt1) : (gnt1 && !gnt0);
        lat = 0;
        d = 1'b0;
        while (!d && lat < 12) begin
            @(posedge clk); #1;
            lat++;
            d = (who == 0) ? done0 : done1;
        end
        r = result; c = carry; v = overflow;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        req0 = 0; req1 = 0; sub0 = 0; sub1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({gnt0, gnt1, done0, done1, carry, overflow, busy} !== 7'b0 || result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs: got flags=%b result=%h, want flags=0000000 result=0000",
                     {gnt0, gnt1, done0, done1, carry, overflow, busy}, result);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_ripple();
        int lat; logic g; logic [15:0] r; logic c, v;
        run_op(0, 1'b0, 16'hFFFF, 16'h0001, lat, g, r, c, v);
        checks++;
        if (lat !== 4 || g !== 1'b1) begin
            errors++;
            $display("FAIL ripple_latency: got lat=%0d gnt_ok=%b, want lat=4 gnt_ok=1", lat, g);
        end
        checks++;
        if (r !== 16'h0000 || c !== 1'b1 || v !== 1'b0) begin
            errors++;
            $display("FAIL ripple_ffff: got r=%h c=%b v=%b, want r=0000 c=1 v=0", r, c, v);
        end
        run_op(0, 1'b0, 16'h1234, 16'h0FFF, lat, g, r, c, v);
        checks++;
        if (r !== 16'h2233 || c !== 1'b0 || v !== 1'b0) begin
            errors++;
            $display("FAIL ripple_1234: got r=%h c=%b v=%b, want r=2233 c=0 v=0", r, c, v);
        end
    endtask

    task automatic test_subtract();
        int lat; logic g; logic [15:0] r; logic c, v;
        run_op(1, 1'b1, 16'h0007, 16'h0005, lat, g, r, c, v);
        checks++;
        if (lat !== 4 || g !== 1'b1) begin
            errors++;
            $display("FAIL sub_latency: got lat=%0d gnt_ok=%b, want lat=4 gnt_ok=1", lat, g);
        end
        checks++;
        if (r !== 16'h0002 || c !== 1'b1 || v !== 1'b0) begin
            errors++;
            $display("FAIL sub_7_5: got r=%h c=%b v=%b, want r=0002 c=1 v=0", r, c, v);
        end
        run_op(1, 1'b1, 16'h0005, 16'h0007, lat, g, r, c, v);
        checks++;
        if (r !== 16'hFFFE || c !== 1'b0 || v !== 1'b0) begin
            errors++;
            $display("FAIL sub_5_7: got r=%h c=%b v=%b, want r=fffe c=0 v=0", r, c, v);
        end
    endtask

    task automatic test_overflow();
        int lat; logic g; logic [15:0] r; logic c, v;
        run_op(0, 1'b0, 16'h7FFF, 16'h0001, lat, g, r, c, v);
        checks++;
        if (r !== 16'h8000 || c !== 1'b0 || v !== 1'b1) begin
            errors++;
            $display("FAIL ovf_add: got r=%h c=%b v=%b, want r=8000 c=0 v=1", r, c, v);
        end
        run_op(1, 1'b1, 16'h8000, 16'h0001, lat, g, r, c, v);
        checks++;
        if (r !== 16'h7FFF || c !== 1'b1 || v !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sub: got r=%h c=%b v=%b, want r=7fff c=1 v=1", r, c, v);
        end
        // Results hold after the done cycle
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (result !== 16'h7FFF || carry !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL result_hold: got r=%h c=%b v=%b, want r=7fff c=1 v=1", result, carry, overflow);
        end
    endtask

    task automatic test_isolation();
        int lat;
        req0 = 1'b1; sub0 = 1'b0; a0 = 16'h1111; b0 = 16'h2222;
        @(posedge clk); #1;
        req0 = 1'b0; sub0 = 1'b1; a0 = 16'hFFFF; b0 = 16'hFFFF;
        lat = 0;
        while (!done0 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || result !== 16'h3333 || carry !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL isolation: got lat=%0d r=%h c=%b v=%b, want lat=4 r=3333 c=0 v=0",
                     lat, result, carry, overflow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration();
        int n_done = 0;
        int who_q[4];
        int cyc_q[4];
        logic [15:0] res_q[4];
        int overlap = 0;
        int lim;
        reset_n = 1'b0;
        req0 = 1'b1; sub0 = 1'b0; a0 = 16'h0001; b0 = 16'h0002;
        req1 = 1'b1; sub1 = 1'b1; a1 = 16'h000A; b1 = 16'h0003;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int cyc = 1; cyc <= 26; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) begin
                checks++;
                if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
                    errors++;
                    $display("FAIL arb_first_grant: got gnt0=%b gnt1=%b, want gnt0=1 gnt1=0", gnt0, gnt1);
                end
            end
            if (gnt0 && gnt1) overlap++;
            if ((done0 || done1) && n_done < 4) begin
                who_q[n_done] = done1 ? 1 : 0;
                cyc_q[n_done] = cyc;
                res_q[n_done] = result;
                n_done++;
            end
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL arb_gnt_overlap: got %0d cycles with both gnt high, want 0", overlap);
        end
        checks++;
        if (n_done != 4) begin
            errors++;
            $display("FAIL arb_done_count: got %0d done pulses, want 4", n_done);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (who_q[k] != (k % 2) || cyc_q[k] != 5 + 6 * k ||
                    res_q[k] !== ((k % 2 == 0) ? 16'h0003 : 16'h0007)) begin
                    errors++;
                    $display("FAIL arb_done_%0d: got who=%0d cyc=%0d r=%h, want who=%0d cyc=%0d r=%h",
                             k, who_q[k], cyc_q[k], res_q[k], k % 2, 5 + 6 * k,
                             (k % 2 == 0) ? 16'h0003 : 16'h0007);
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        lim = 0;
        while (busy && lim < 10) begin
            @(posedge clk); #1;
            lim++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL arb_drain: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_reset_midop();
        int saw_done = 0;
        int lat;
        req0 = 1'b1; sub0 = 1'b0; a0 = 16'h1234; b0 = 16'h1111;
        @(posedge clk); #1;
        req0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({gnt0, gnt1, done0, done1, carry, overflow, busy} !== 7'b0 || result !== 16'h0000) begin
            errors++;
            $display("FAIL midop_reset_outputs: got flags=%b result=%h, want flags=0000000 result=0000",
                     {gnt0, gnt1, done0, done1, carry, overflow, busy}, result);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done0 || done1) saw_done++;
        end
        checks++;
        if (saw_done != 0 || result !== 16'h0000) begin
            errors++;
            $display("FAIL midop_no_done: got %0d done pulses r=%h, want 0 pulses r=0000", saw_done, result);
        end
        // Pointer must be back at 0, so a simultaneous request goes to requester 0
        req0 = 1'b1; sub0 = 1'b0; a0 = 16'h0100; b0 = 16'h0023;
        req1 = 1'b1; sub1 = 1'b0; a1 = 16'h5555; b1 = 16'h5555;
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL midop_ptr_restart: got gnt0=%b gnt1=%b, want gnt0=1 gnt1=0", gnt0, gnt1);
        end
        lat = 0;
        while (!done0 && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 4 || result !== 16'h0123 || carry !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL midop_recover: got lat=%0d r=%h c=%b v=%b, want lat=4 r=0123 c=0 v=0",
                     lat, result, carry, overflow);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_subtract();
        test_overflow();
        test_isolation();
        test_arbitration();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_sub_arbiter_seq.md
# add_sub_arbiter_seq

Shared 16-bit add/subtract engine with a two-requester round-robin arbiter. Each granted operation is computed nibble-serially over four cycles through a single 4-bit add/sub slice with a registered carry. It lets two client blocks share one small adder instead of each instantiating a full 16-bit adder, and it returns the result with carry/borrow and signed-overflow flags.

## Interface
Parameters:
- none (width fixed at 16 bits, slice fixed at 4 bits)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- req0, req1  in  1 each  level request from requester 0 / 1
- sub0, sub1  in  1 each  operation select: 0 = A+B, 1 = A−B
- a0, b0, a1, b1  in  16 each  operands for requester 0 / 1
- gnt0, gnt1  out  1 each  high from the acceptance edge through the done cycle of that requester's operation
- done0, done1  out  1 each  one-cycle completion pulse to the owning requester
- result  out  16  sum or difference, held until the next completion
- carry  out  1  add: carry-out; sub: 1 = no borrow (A ≥ B unsigned), 0 = borrow
- overflow  out  1  two's-complement signed overflow of the operation
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, CALC (nibble index 0..3), DONE.
- IDLE: if any req is high at a rising edge, grant one requester.
  - Copy its a, b and sub into internal registers.
  - Load the slice carry register with sub (0 for add, 1 for subtract).
  - Clear nibble index to 0, go to CALC.
  - Only one requester high: grant that one.
  - Both high: grant the requester the priority pointer selects.
- Priority pointer: reset value 0. After each grant it points to the requester not granted.
- CALC, per cycle i:
  - {c_out, r[4i+3:4i]} = A[4i+3:4i] + (B[4i+3:4i] ^ {4{sub}}) + c_reg.
  - c_reg ← c_out; write the result nibble into the internal result shift register.
  - After i = 3, go to DONE.
- DONE:
  - Update result, carry (final c_reg) and overflow together.
  - Pulse the granted done for one cycle; deassert its gnt at the end of this cycle; return to IDLE.
- Overflow:
  - add: a15 == b15 and r15 != a15.
  - sub: a15 != b15 and r15 != a15.
- Operands are sampled only at the acceptance edge. Later changes on a/b/sub, including from the granted requester, do not affect the running operation.
- Requests are level-sensitive. If req stays high through DONE, it is a new request, arbitrated in the following IDLE cycle against the current pointer.
- A request from the non-granted requester while the engine is busy is not lost. It is serviced once the engine returns to IDLE, provided req is still high.
- Reset mid-operation:
  - State → IDLE; pointer → 0.
  - result, carry, overflow, gnt*, done*, busy → 0.
  - No done pulse for the aborted operation.

## Timing
- Reset values: result = 16'h0000; carry, overflow, gnt0, gnt1, done0, done1, busy all 0.
- Acceptance edge E (IDLE, req high): gnt and busy rise after E.
- CALC occupies the 4 cycles after E; DONE is the 5th cycle after E.
- done and the updated result/carry/overflow are visible during the DONE cycle, i.e. 5 clocks after E. result/carry/overflow hold their values after that.
- Engine returns to IDLE 6 clocks after E. The next earliest acceptance edge is E+6.
- Minimum issue interval: 6 cycles; throughput one operation per 6 cycles.
- Arbitration decision is combinational on req in IDLE and takes effect at the acceptance edge. No grant is issued in CALC or DONE.

## Test plan
- Ripple: req0 with add, 0xFFFF + 0x0001 → after 5 clocks done0, result 0x0000, carry 1, overflow 0. Also 0x1234 + 0x0FFF → 0x2233, carry 0.
- Subtract: req1 with sub, 0x0007 − 0x0005 → 0x0002, carry 1. Then 0x0005 − 0x0007 → 0xFFFE, carry 0, overflow 0.
- Overflow: 0x7FFF + 0x0001 → 0x8000, overflow 1, carry 0. Also 0x8000 − 0x0001 → 0x7FFF, overflow 1, carry 1.
- Arbitration: req0 and req1 both held high continuously → grants alternate 0, 1, 0, 1, first grant to requester 0, each done 6 cycles apart. Never two gnt high at once.
- Operand isolation: change a0/b0/sub0 on the cycle after acceptance → result matches the originally sampled operands.
- Reset mid-op: assert reset_n low during CALC nibble 2 → all outputs 0 immediately, no done. After release, a new req0 completes normally with the pointer restarting at 0.
